// File: rtl/block_sync_lock_pkg.sv
// Shared definitions for the multi-lane 64b/66b block-lock engine.
package block_sync_lock_pkg;

  // One-hot lane FSM encoding.
  typedef enum logic [4:0] {
    StInit     = 5'b00001,
    StResetCnt = 5'b00010,
    StTestSh   = 5'b00100,
    StSlip     = 5'b01000,
    StSlipWait = 5'b10000
  } lane_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_lock_lane.sv
// One lane of the block-lock engine: sync-header FSM, slip control and error counter.
module block_lock_lane
  import block_sync_lock_pkg::*;
#(
  parameter int unsigned WIN_LEN       = 64,
  parameter int unsigned MAX_INVALID   = 16,
  parameter int unsigned SLIP_WAIT_CYC = 32,
  parameter int unsigned MAX_SLIP      = 132,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lane_en_i,
  input  logic             cnt_clr_i,
  input  logic             sh_vld_i,
  input  logic [1:0]       sh_dat_i,
  output logic             slip_o,
  output logic             block_lock_o,
  output logic             lock_lost_o,
  output logic             lane_fail_o,
  output logic [CNT_W-1:0] hdr_err_cnt_o
);

  localparam int unsigned HdrW  = cnt_width(WIN_LEN);
  localparam int unsigned InvW  = cnt_width(MAX_INVALID);
  localparam int unsigned SlipW = cnt_width(MAX_SLIP);
  localparam int unsigned WaitW = cnt_width(SLIP_WAIT_CYC);

  localparam logic [HdrW-1:0]  WinLast  = HdrW'(WIN_LEN - 1);
  localparam logic [InvW-1:0]  InvLast  = InvW'(MAX_INVALID - 1);
  localparam logic [SlipW-1:0] SlipMax  = SlipW'(MAX_SLIP);
  localparam logic [WaitW-1:0] WaitLast = WaitW'((SLIP_WAIT_CYC == 0) ? 0 : SLIP_WAIT_CYC - 1);

  lane_state_e      state_q;
  logic [HdrW-1:0]  hdr_q;
  logic [InvW-1:0]  inv_q;
  logic [WaitW-1:0] wait_q;
  logic [SlipW-1:0] slip_cnt_q, slip_cnt_d;
  logic             lock_q, lost_q, slip_q, fail_q;
  logic [CNT_W-1:0] err_q;
  logic             hdr_bad;

  assign hdr_bad = sh_vld_i && !sh_is_valid(sh_dat_i);

  // Saturating slip count for the slip being issued now.
  always_comb begin
    slip_cnt_d = (slip_cnt_q == SlipMax) ? slip_cnt_q : slip_cnt_q + 1'b1;
  end

  // Lane FSM with window counters and registered lock/slip/fail outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      hdr_q      <= '0;
      inv_q      <= '0;
      wait_q     <= '0;
      slip_cnt_q <= '0;
      lock_q     <= 1'b0;
      lost_q     <= 1'b0;
      slip_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else if (!lane_en_i) begin
      // Disabling is silent: no lock_lost pulse, lane restarts from INIT.
      state_q    <= StInit;
      hdr_q      <= '0;
      inv_q      <= '0;
      wait_q     <= '0;
      slip_cnt_q <= '0;
      lock_q     <= 1'b0;
      lost_q     <= 1'b0;
      slip_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      slip_q <= 1'b0;
      unique case (state_q)
        StInit: state_q <= StResetCnt;
        StResetCnt: begin
          hdr_q   <= '0;
          inv_q   <= '0;
          state_q <= StTestSh;
        end
        StTestSh: begin
          if (sh_vld_i) begin
            hdr_q <= hdr_q + 1'b1;
            inv_q <= inv_q + InvW'(hdr_bad);
            // Slip takes priority over the window-end decision.
            if (hdr_bad && (!lock_q || (inv_q == InvLast))) begin
              state_q    <= StSlip;
              slip_q     <= 1'b1;
              slip_cnt_q <= slip_cnt_d;
              if (slip_cnt_d == SlipMax) fail_q <= 1'b1;
              if (lock_q) begin
                lock_q <= 1'b0;
                lost_q <= 1'b1;
              end
            end else if (hdr_q == WinLast) begin
              state_q <= StResetCnt;
              if ((inv_q == '0) && !hdr_bad) begin
                lock_q     <= 1'b1;
                slip_cnt_q <= '0;
              end
            end
          end
        end
        StSlip: begin
          wait_q  <= '0;
          state_q <= (SLIP_WAIT_CYC == 0) ? StResetCnt : StSlipWait;
        end
        StSlipWait: begin
          if (wait_q == WaitLast) state_q <= StResetCnt;
          else                    wait_q  <= wait_q + 1'b1;
        end
        default: state_q <= StInit;
      endcase
      if (cnt_clr_i) begin
        slip_cnt_q <= '0;
        fail_q     <= 1'b0;
      end
    end
  end

  // Saturating bad-header counter; clear beats a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else if (cnt_clr_i) begin
      err_q <= '0;
    end else if (lane_en_i && hdr_bad && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign slip_o        = slip_q;
  assign block_lock_o  = lock_q;
  assign lock_lost_o   = lost_q;
  assign lane_fail_o   = fail_q;
  assign hdr_err_cnt_o = err_q;

endmodule

// File: rtl/block_sync_lock.sv
// Multi-lane 64b/66b block-lock engine: independent lanes plus an all-lanes-locked flag.
module block_sync_lock
  import block_sync_lock_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned WIN_LEN       = 64,
  parameter int unsigned MAX_INVALID   = 16,
  parameter int unsigned SLIP_WAIT_CYC = 32,
  parameter int unsigned MAX_SLIP      = 132,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES-1:0]       lane_en,
  input  logic [NUM_LANES-1:0]       sh_vld,
  input  logic [2*NUM_LANES-1:0]     sh_dat,
  input  logic                       cnt_clr,
  output logic [NUM_LANES-1:0]       slip,
  output logic [NUM_LANES-1:0]       block_lock,
  output logic [NUM_LANES-1:0]       lock_lost,
  output logic [NUM_LANES-1:0]       lane_fail,
  output logic                       all_locked,
  output logic [CNT_W*NUM_LANES-1:0] hdr_err_cnt
);

  logic all_locked_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    block_lock_lane #(
      .WIN_LEN      (WIN_LEN),
      .MAX_INVALID  (MAX_INVALID),
      .SLIP_WAIT_CYC(SLIP_WAIT_CYC),
      .MAX_SLIP     (MAX_SLIP),
      .CNT_W        (CNT_W)
    ) u_lane (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .lane_en_i    (lane_en[i]),
      .cnt_clr_i    (cnt_clr),
      .sh_vld_i     (sh_vld[i]),
      .sh_dat_i     (sh_dat[2*i +: 2]),
      .slip_o       (slip[i]),
      .block_lock_o (block_lock[i]),
      .lock_lost_o  (lock_lost[i]),
      .lane_fail_o  (lane_fail[i]),
      .hdr_err_cnt_o(hdr_err_cnt[CNT_W*i +: CNT_W])
    );
  end

  // Disabled lanes are don't-care; with no lane enabled the flag stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_locked_q <= 1'b0;
    else        all_locked_q <= (|lane_en) && (&(block_lock | ~lane_en));
  end

  assign all_locked = all_locked_q;

endmodule

// File: tb/tb_block_sync_lock.sv
// Self-checking bench for block_sync_lock: directed scenarios plus randomized run vs. a model.
module tb_block_sync_lock;
  localparam int unsigned NL = 2, WL = 8, MI = 3, SW = 2, MS = 4, CW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NL-1:0]    lane_en = '0, sh_vld = '0;
  logic [2*NL-1:0]  sh_dat = '0;
  logic             cnt_clr = 1'b0;
  logic [NL-1:0]    slip, block_lock, lock_lost, lane_fail;
  logic             all_locked;
  logic [CW*NL-1:0] hdr_err_cnt;

  int n_chk = 0, n_pass = 0;

  // Model: per lane, "skip" = upcoming edges at which headers are ignored.
  bit m_lock[NL], m_slip[NL], m_lost[NL], m_fail[NL];
  int m_skip[NL], m_hdrs[NL], m_bad[NL], m_slips[NL], m_err[NL];
  bit m_all;

  block_sync_lock #(
    .NUM_LANES(NL), .WIN_LEN(WL), .MAX_INVALID(MI), .SLIP_WAIT_CYC(SW), .MAX_SLIP(MS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lane_en(lane_en), .sh_vld(sh_vld), .sh_dat(sh_dat),
    .cnt_clr(cnt_clr), .slip(slip), .block_lock(block_lock), .lock_lost(lock_lost),
    .lane_fail(lane_fail), .all_locked(all_locked), .hdr_err_cnt(hdr_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic set_hdr(input int lane, input logic vld, input logic [1:0] code);
    sh_vld[lane] = vld;
    sh_dat[2*lane +: 2] = code;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_lock[i] = 0; m_slip[i] = 0; m_lost[i] = 0; m_fail[i] = 0;
      m_skip[i] = 2; m_hdrs[i] = 0; m_bad[i] = 0; m_slips[i] = 0; m_err[i] = 0;
    end
    m_all = 0;
  endtask

  task automatic model_edge();
    int  n_en;
    bit  ok, bad, new_all;
    logic [1:0] h;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n_en = 0; ok = 1;
    for (int i = 0; i < NL; i++) if (lane_en[i]) begin
      n_en++;
      if (!m_lock[i]) ok = 0;
    end
    new_all = (n_en > 0) && ok;
    for (int i = 0; i < NL; i++) begin
      h = sh_dat[2*i +: 2];
      bad = sh_vld[i] && ((h == 2'b00) || (h == 2'b11));
      m_slip[i] = 0; m_lost[i] = 0;
      if (cnt_clr) m_err[i] = 0;
      else if (lane_en[i] && bad && m_err[i] < (1 << CW) - 1) m_err[i]++;
      if (!lane_en[i]) begin
        m_lock[i] = 0; m_fail[i] = 0; m_slips[i] = 0; m_skip[i] = 2; m_hdrs[i] = 0; m_bad[i] = 0;
      end else if (m_skip[i] > 0) begin
        m_skip[i]--;
      end else if (sh_vld[i]) begin
        m_hdrs[i]++;
        if (bad) m_bad[i]++;
        if (bad && (!m_lock[i] || m_bad[i] == MI)) begin
          m_lost[i] = m_lock[i];
          m_lock[i] = 0; m_slip[i] = 1;
          if (m_slips[i] < MS) m_slips[i]++;
          if (m_slips[i] == MS) m_fail[i] = 1;
          m_skip[i] = SW + 2; m_hdrs[i] = 0; m_bad[i] = 0;
        end else if (m_hdrs[i] == WL) begin
          if (m_bad[i] == 0) begin m_lock[i] = 1; m_slips[i] = 0; end
          m_skip[i] = 1; m_hdrs[i] = 0; m_bad[i] = 0;
        end
      end
      if (cnt_clr) begin m_fail[i] = 0; m_slips[i] = 0; end
    end
    m_all = new_all;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    lane_en = 2'b11;
    tick(); tick();
    n_chk++; if (slip !== 2'b00) $display("FAIL rst_slip: got %b want 00", slip); else n_pass++;
    n_chk++; if (block_lock !== 2'b00) $display("FAIL rst_lock: got %b want 00", block_lock); else n_pass++;
    n_chk++; if (lock_lost !== 2'b00) $display("FAIL rst_lost: got %b want 00", lock_lost); else n_pass++;
    n_chk++; if (lane_fail !== 2'b00) $display("FAIL rst_fail: got %b want 00", lane_fail); else n_pass++;
    n_chk++; if (all_locked !== 1'b0) $display("FAIL rst_all: got %b want 0", all_locked); else n_pass++;
    n_chk++; if (hdr_err_cnt !== '0) $display("FAIL rst_err: got %h want 0", hdr_err_cnt); else n_pass++;
    lane_en = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    lane_en = 2'b01;
    tick(); tick();
    for (int k = 0; k < WL; k++) begin
      set_hdr(0, 1'b1, good_hdr());
      tick();
      n_chk++; if (slip[0] !== 1'b0) $display("FAIL lock_no_slip: got %b want 0", slip[0]); else n_pass++;
      if (k == WL - 2) begin
        n_chk++;
        if (block_lock[0] !== 1'b0) $display("FAIL lock_early: got %b want 0", block_lock[0]);
        else n_pass++;
      end
    end
    n_chk++; if (block_lock[0] !== 1'b1) $display("FAIL lock_at_8th: got %b want 1", block_lock[0]); else n_pass++;
    n_chk++; if (all_locked !== 1'b0) $display("FAIL all_lat: got %b want 0", all_locked); else n_pass++;
    sh_vld = '0;
    tick();
    n_chk++; if (all_locked !== 1'b1) $display("FAIL all_rise: got %b want 1", all_locked); else n_pass++;
  endtask

  task automatic test_lock_loss();
    for (int k = 0; k < WL; k++) begin
      set_hdr(0, 1'b1, (k == 2 || k == 5) ? bad_hdr() : good_hdr());
      tick();
    end
    n_chk++; if (block_lock[0] !== 1'b1) $display("FAIL hold_2bad: got %b want 1", block_lock[0]); else n_pass++;
    n_chk++; if (slip[0] !== 1'b0) $display("FAIL hold_no_slip: got %b want 0", slip[0]); else n_pass++;
    sh_vld = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_hdr(0, 1'b1, bad_hdr());
      tick();
      if (k < 2) begin
        n_chk++;
        if (block_lock[0] !== 1'b1) $display("FAIL hold_pre3: got %b want 1", block_lock[0]);
        else n_pass++;
      end
    end
    n_chk++; if (lock_lost[0] !== 1'b1) $display("FAIL lost_pulse: got %b want 1", lock_lost[0]); else n_pass++;
    n_chk++; if (block_lock[0] !== 1'b0) $display("FAIL lost_lock: got %b want 0", block_lock[0]); else n_pass++;
    n_chk++; if (slip[0] !== 1'b1) $display("FAIL lost_slip: got %b want 1", slip[0]); else n_pass++;
    n_chk++; if (all_locked !== 1'b1) $display("FAIL all_fall_lat: got %b want 1", all_locked); else n_pass++;
    sh_vld = '0;
    tick();
    n_chk++; if (lock_lost[0] !== 1'b0) $display("FAIL lost_one_cyc: got %b want 0", lock_lost[0]); else n_pass++;
    n_chk++; if (slip[0] !== 1'b0) $display("FAIL slip_one_cyc: got %b want 0", slip[0]); else n_pass++;
    n_chk++; if (all_locked !== 1'b0) $display("FAIL all_fall: got %b want 0", all_locked); else n_pass++;
  endtask

  task automatic test_slip_wait();
    lane_en = 2'b00; sh_vld = '0;
    tick();
    lane_en = 2'b01;
    tick(); tick();
    set_hdr(0, 1'b1, good_hdr()); tick();
    set_hdr(0, 1'b1, good_hdr()); tick();
    set_hdr(0, 1'b1, 2'b11); tick();
    n_chk++; if (slip[0] !== 1'b1) $display("FAIL slip_on_3rd: got %b want 1", slip[0]); else n_pass++;
    for (int k = 0; k < SW + 2; k++) begin
      set_hdr(0, 1'b1, 2'b00);
      tick();
      n_chk++; if (slip[0] !== 1'b0) $display("FAIL wait_ignored: got %b want 0", slip[0]); else n_pass++;
    end
    for (int k = 0; k < WL; k++) begin
      set_hdr(0, 1'b1, good_hdr());
      tick();
    end
    n_chk++; if (block_lock[0] !== 1'b1) $display("FAIL relock: got %b want 1", block_lock[0]); else n_pass++;
    sh_vld = '0;
  endtask

  task automatic test_lane_fail();
    int   pulses;
    bit   got;
    logic exp_f;
    lane_en = 2'b00; sh_vld = '0;
    tick();
    lane_en = 2'b01;
    pulses = 0;
    for (int c = 0; c < 60 && pulses < 4; c++) begin
      set_hdr(0, 1'b1, 2'b00);
      tick();
      if (slip[0]) begin
        pulses++;
        exp_f = (pulses >= MS);
        n_chk++;
        if (lane_fail[0] !== exp_f) $display("FAIL fail_at_slip%0d: got %b want %b", pulses, lane_fail[0], exp_f);
        else n_pass++;
      end
    end
    n_chk++; if (pulses != 4) $display("FAIL slip_count: got %0d want 4", pulses); else n_pass++;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    n_chk++; if (lane_fail[0] !== 1'b0) $display("FAIL fail_clr: got %b want 0", lane_fail[0]); else n_pass++;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (slip[0]) got = 1;
    end
    n_chk++; if (!got) $display("FAIL slip_after_clr: got none want pulse"); else n_pass++;
    sh_vld = '0;
  endtask

  task automatic test_err_sat();
    lane_en = 2'b01; sh_vld = '0;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    n_chk++; if (hdr_err_cnt !== '0) $display("FAIL err_clr: got %h want 0", hdr_err_cnt); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      set_hdr(0, 1'b1, bad_hdr());
      set_hdr(1, 1'b1, 2'b11);
      tick();
      if (k == 13) begin
        n_chk++;
        if (hdr_err_cnt[CW-1:0] !== 4'd14) $display("FAIL err_count: got %0d want 14", hdr_err_cnt[CW-1:0]);
        else n_pass++;
      end
    end
    n_chk++; if (hdr_err_cnt[CW-1:0] !== 4'hf) $display("FAIL err_sat: got %0d want 15", hdr_err_cnt[CW-1:0]); else n_pass++;
    n_chk++; if (hdr_err_cnt[2*CW-1:CW] !== 4'd0) $display("FAIL err_dis_lane: got %0d want 0", hdr_err_cnt[2*CW-1:CW]); else n_pass++;
    set_hdr(0, 1'b1, 2'b00);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    n_chk++; if (hdr_err_cnt[CW-1:0] !== 4'd0) $display("FAIL err_clr_inc: got %0d want 0", hdr_err_cnt[CW-1:0]); else n_pass++;
    sh_vld = '0;
  endtask

  task automatic test_all_locked();
    bit got;
    lane_en = 2'b00; sh_vld = '0;
    tick();
    lane_en = 2'b01;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      set_hdr(0, 1'b1, good_hdr());
      tick();
      if (block_lock[0]) got = 1;
    end
    n_chk++; if (!got) $display("FAIL lane0_lock: got 0 want 1"); else n_pass++;
    lane_en = 2'b11;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      set_hdr(0, 1'b1, good_hdr());
      set_hdr(1, 1'b1, good_hdr());
      tick();
      if (block_lock[1]) got = 1;
    end
    n_chk++; if (!got) $display("FAIL lane1_lock: got 0 want 1"); else n_pass++;
    n_chk++; if (all_locked !== 1'b0) $display("FAIL all_wait: got %b want 0", all_locked); else n_pass++;
    n_chk++; if (block_lock[0] !== 1'b1) $display("FAIL lane0_held: got %b want 1", block_lock[0]); else n_pass++;
    set_hdr(0, 1'b1, good_hdr());
    set_hdr(1, 1'b1, good_hdr());
    tick();
    n_chk++; if (all_locked !== 1'b1) $display("FAIL all_two: got %b want 1", all_locked); else n_pass++;
    lane_en = 2'b01;
    tick();
    n_chk++; if (block_lock[1] !== 1'b0) $display("FAIL dis_lock: got %b want 0", block_lock[1]); else n_pass++;
    n_chk++; if (lock_lost[1] !== 1'b0) $display("FAIL dis_no_lost: got %b want 0", lock_lost[1]); else n_pass++;
    n_chk++; if (all_locked !== 1'b1) $display("FAIL all_one: got %b want 1", all_locked); else n_pass++;
    lane_en = 2'b00;
    tick();
    n_chk++; if (all_locked !== 1'b0) $display("FAIL all_none: got %b want 0", all_locked); else n_pass++;
    n_chk++; if (block_lock !== 2'b00) $display("FAIL none_lock: got %b want 00", block_lock); else n_pass++;
    sh_vld = '0;
  endtask

  task automatic test_reset_mid_wait();
    lane_en = 2'b01; sh_vld = '0;
    tick(); tick();
    set_hdr(0, 1'b1, 2'b11); tick();
    n_chk++; if (slip[0] !== 1'b1) $display("FAIL pre_rst_slip: got %b want 1", slip[0]); else n_pass++;
    sh_vld = '0;
    tick();
    n_chk++; if (hdr_err_cnt[CW-1:0] !== 4'd1) $display("FAIL pre_rst_err: got %0d want 1", hdr_err_cnt[CW-1:0]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({slip, block_lock, lock_lost, lane_fail, all_locked, hdr_err_cnt} !== '0)
      $display("FAIL async_rst: got %b/%b/%b/%b/%b/%h want all 0",
               slip, block_lock, lock_lost, lane_fail, all_locked, hdr_err_cnt);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int bad_den;
    int dens[4] = '{0, 32, 8, 2};
    logic [CW-1:0] e;
    rst_n = 1'b0; lane_en = '0; sh_vld = '0; cnt_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    lane_en = 2'b11;
    bad_den = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) bad_den = dens[$urandom_range(0, 3)];
      if ($urandom_range(0, 199) == 0) lane_en[$urandom_range(0, NL - 1)] ^= 1'b1;
      cnt_clr = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NL; i++)
        set_hdr(i, $urandom_range(0, 3) != 0,
                (bad_den > 0 && $urandom_range(0, bad_den - 1) == 0) ? bad_hdr() : good_hdr());
      tick();
      for (int i = 0; i < NL; i++) begin
        e = m_err[i][CW-1:0];
        n_chk++; if (slip[i] !== m_slip[i]) $display("FAIL rnd_slip c%0d l%0d: got %b want %b", c, i, slip[i], m_slip[i]); else n_pass++;
        n_chk++; if (block_lock[i] !== m_lock[i]) $display("FAIL rnd_lock c%0d l%0d: got %b want %b", c, i, block_lock[i], m_lock[i]); else n_pass++;
        n_chk++; if (lock_lost[i] !== m_lost[i]) $display("FAIL rnd_lost c%0d l%0d: got %b want %b", c, i, lock_lost[i], m_lost[i]); else n_pass++;
        n_chk++; if (lane_fail[i] !== m_fail[i]) $display("FAIL rnd_fail c%0d l%0d: got %b want %b", c, i, lane_fail[i], m_fail[i]); else n_pass++;
        n_chk++; if (hdr_err_cnt[CW*i +: CW] !== e) $display("FAIL rnd_err c%0d l%0d: got %0d want %0d", c, i, hdr_err_cnt[CW*i +: CW], e); else n_pass++;
      end
      n_chk++; if (all_locked !== m_all) $display("FAIL rnd_all c%0d: got %b want %b", c, all_locked, m_all); else n_pass++;
    end
    cnt_clr = 1'b0; sh_vld = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_lock_loss();
    test_slip_wait();
    test_lane_fail();
    test_err_sat();
    test_all_locked();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
